// File: rtl/gpio_pattern_sequencer_if.sv
// Control/status bundle for gpio_pattern_sequencer.
//   master: the controlling logic (drives start/stop/loop_en and table writes,
//           observes busy/done/step_idx and the a/b pins).
//   slave:  the sequencer itself.
// STEPS and DUR_W must match the parameters of the attached sequencer.
interface gpio_pattern_sequencer_if #(
  parameter int unsigned STEPS = 4,
  parameter int unsigned DUR_W = 8
);
  localparam int unsigned IdxW = $clog2(STEPS);

  logic            start;
  logic            stop;
  logic            loop_en;
  logic            cfg_we;
  logic [IdxW-1:0] cfg_addr;
  logic [1:0]      cfg_pattern;
  logic [DUR_W-1:0] cfg_duration;

  logic            busy;
  logic            done;
  logic [IdxW-1:0] step_idx;
  logic            a;
  logic            b;

  modport master (
    output start, stop, loop_en, cfg_we, cfg_addr, cfg_pattern, cfg_duration,
    input  busy, done, step_idx, a, b
  );

  modport slave (
    input  start, stop, loop_en, cfg_we, cfg_addr, cfg_pattern, cfg_duration,
    output busy, done, step_idx, a, b
  );
endinterface

// File: rtl/gpio_pattern_sequencer.sv
// Programmable pattern scheduler for the two GPIO pins a/b.
// Plays a table of (2-bit pattern, duration) steps in order. Each step lasts
// (duration+1) prescaler ticks; one tick every 2**PRESCALE_W clocks.
// Ports:
//   clk    system clock (HFOSC), single domain
//   rst_n  synchronous active-low reset; also clears the step table
//   bus    gpio_pattern_sequencer_if.slave:
//            start/stop/loop_en   playback control
//            cfg_we/cfg_addr/cfg_pattern/cfg_duration   table write port
//            busy/done/step_idx   status (all registered)
//            a/b                  GPIO pins, pattern bit1/bit0 (registered)
module gpio_pattern_sequencer #(
  parameter int unsigned PRESCALE_W = 4,
  parameter int unsigned STEPS      = 4,
  parameter int unsigned DUR_W      = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  gpio_pattern_sequencer_if.slave bus
);

  localparam int unsigned IdxW = $clog2(STEPS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(STEPS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic [DUR_W-1:0]      dcnt_q;
  logic [IdxW-1:0]       step_idx_q;
  logic                  a_q;
  logic                  b_q;
  logic                  busy_q;
  logic                  done_q;

  logic [1:0]       pat_q [STEPS];
  logic [DUR_W-1:0] dur_q [STEPS];

  logic            tick;
  logic            step_end;
  logic [IdxW-1:0] next_idx;

  assign tick     = &presc_q;
  assign step_end = tick && (dcnt_q == dur_q[step_idx_q]);
  assign next_idx = step_idx_q + IdxW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      dcnt_q     <= '0;
      step_idx_q <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < int'(STEPS); i++) begin
        pat_q[i] <= '0;
        dur_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // stop wins over a simultaneous start
          if (bus.start && !bus.stop) begin
            state_q    <= StRun;
            presc_q    <= '0;
            dcnt_q     <= '0;
            step_idx_q <= '0;
            {a_q, b_q} <= pat_q[0];
            busy_q     <= 1'b1;
          end
        end

        StRun: begin
          if (bus.stop) begin
            // abort beats any end-of-step on the same edge; no done pulse
            state_q    <= StIdle;
            presc_q    <= '0;
            dcnt_q     <= '0;
            step_idx_q <= '0;
            {a_q, b_q} <= 2'b00;
            busy_q     <= 1'b0;
          end else begin
            presc_q <= presc_q + PRESCALE_W'(1);
            if (tick && !step_end) begin
              dcnt_q <= dcnt_q + DUR_W'(1);
            end else if (step_end) begin
              dcnt_q <= '0;
              if (step_idx_q != LastIdx) begin
                step_idx_q <= next_idx;
                {a_q, b_q} <= pat_q[next_idx];
              end else if (bus.loop_en) begin
                step_idx_q <= '0;
                {a_q, b_q} <= pat_q[0];
              end else begin
                state_q    <= StIdle;
                step_idx_q <= '0;
                {a_q, b_q} <= 2'b00;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end
            end
          end
        end

        default: state_q <= StIdle;
      endcase

      // Table reads above see the pre-write contents (old value on collision).
      if (bus.cfg_we) begin
        pat_q[bus.cfg_addr] <= bus.cfg_pattern;
        dur_q[bus.cfg_addr] <= bus.cfg_duration;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_idx = step_idx_q;
  assign bus.a        = a_q;
  assign bus.b        = b_q;

endmodule
